// File: rtl/mem_data_arbiter_if.sv
// Request/response bundle between the two requesters (CPU MEM stage, loader) and the
// data-memory arbiter. Signal names keep the arbiter's port-level direction prefixes.
interface mem_data_arbiter_if;
   logic        i_req0_valid;
   logic        o_req0_ready;
   logic        i_req0_write;
   logic [31:0] i_req0_addr;
   logic [31:0] i_req0_wdata;
   logic        o_rsp0_valid;
   logic        i_rsp0_ready;
   logic [31:0] o_rsp0_rdata;
   logic        o_rsp0_err;

   logic        i_req1_valid;
   logic        o_req1_ready;
   logic        i_req1_write;
   logic [31:0] i_req1_addr;
   logic [31:0] i_req1_wdata;
   logic        o_rsp1_valid;
   logic        i_rsp1_ready;
   logic [31:0] o_rsp1_rdata;
   logic        o_rsp1_err;

   modport slave (
      input  i_req0_valid, i_req0_write, i_req0_addr, i_req0_wdata, i_rsp0_ready,
      input  i_req1_valid, i_req1_write, i_req1_addr, i_req1_wdata, i_rsp1_ready,
      output o_req0_ready, o_rsp0_valid, o_rsp0_rdata, o_rsp0_err,
      output o_req1_ready, o_rsp1_valid, o_rsp1_rdata, o_rsp1_err
   );

   modport master (
      output i_req0_valid, i_req0_write, i_req0_addr, i_req0_wdata, i_rsp0_ready,
      output i_req1_valid, i_req1_write, i_req1_addr, i_req1_wdata, i_rsp1_ready,
      input  o_req0_ready, o_rsp0_valid, o_rsp0_rdata, o_rsp0_err,
      input  o_req1_ready, o_rsp1_valid, o_rsp1_rdata, o_rsp1_err
   );
endinterface

// File: rtl/mem_data_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-ported data memory.
// One access in flight; misaligned or out-of-window requests are answered without a strobe.
module mem_data_arbiter #(
   parameter int unsigned ACC_CYCLES = 2,
   parameter logic [31:0] ADDR_LO    = 32'h0000_3000,
   parameter logic [31:0] ADDR_HI    = 32'h000E_FFFC
) (
   input  logic               i_clk,
   input  logic               i_rst,
   mem_data_arbiter_if.slave  bus,
   output logic               o_memwrite,
   output logic               o_memread,
   output logic [31:0]        o_address,
   output logic [31:0]        o_write_data,
   input  logic [31:0]        i_read_data
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   localparam int unsigned   CntW    = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ACC_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              port_q, port_d;
   logic              memwrite_q, memwrite_d;
   logic              memread_q, memread_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        rsp_valid_q, rsp_valid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              grant0, grant1;
   logic              ready0, ready1;
   logic              accept, sel;
   logic              sel_write;
   logic [31:0]       sel_addr, sel_wdata;
   logic              addr_bad;
   logic              rsp_ready_sel;

   // Round robin: a lone requester always wins; on contention the port that did not win last.
   always_comb begin
      grant0    = bus.i_req0_valid & (~bus.i_req1_valid | last_q);
      grant1    = bus.i_req1_valid & (~bus.i_req0_valid | ~last_q);
      ready0    = (state_q == StIdle) & ~i_rst & grant0;
      ready1    = (state_q == StIdle) & ~i_rst & grant1;
      accept    = ready0 | ready1;
      sel       = ready1;
      sel_write = sel ? bus.i_req1_write : bus.i_req0_write;
      sel_addr  = sel ? bus.i_req1_addr  : bus.i_req0_addr;
      sel_wdata = sel ? bus.i_req1_wdata : bus.i_req0_wdata;
      addr_bad  = (sel_addr[1:0] != 2'b00) | (sel_addr < ADDR_LO) | (sel_addr > ADDR_HI);
      rsp_ready_sel = port_q ? bus.i_rsp1_ready : bus.i_rsp0_ready;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      port_d      = port_q;
      memwrite_d  = memwrite_q;
      memread_d   = memread_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               last_d = sel;
               port_d = sel;
               if (addr_bad) begin
                  state_d     = StResp;
                  rsp_valid_d = sel ? 2'b10 : 2'b01;
                  rdata_d     = '0;
                  err_d       = 1'b1;
               end else begin
                  state_d    = StAccess;
                  cnt_d      = '0;
                  memwrite_d = sel_write;
                  memread_d  = ~sel_write;
                  addr_d     = sel_addr;
                  wdata_d    = sel_write ? sel_wdata : 32'h0;
               end
            end
         end
         StAccess: begin
            if (cnt_q == CntLast) begin
               state_d     = StResp;
               memwrite_d  = 1'b0;
               memread_d   = 1'b0;
               addr_d      = '0;
               wdata_d     = '0;
               rsp_valid_d = port_q ? 2'b10 : 2'b01;
               rdata_d     = memread_q ? i_read_data : 32'h0;
               err_d       = 1'b0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StResp: begin
            if (rsp_ready_sel) begin
               state_d     = StIdle;
               rsp_valid_d = '0;
               rdata_d     = '0;
               err_d       = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Reset also discards any latched request, so an aborted access never responds.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         last_q      <= 1'b1;
         port_q      <= 1'b0;
         memwrite_q  <= 1'b0;
         memread_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         port_q      <= port_d;
         memwrite_q  <= memwrite_d;
         memread_q   <= memread_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign bus.o_req0_ready = ready0;
   assign bus.o_req1_ready = ready1;
   assign bus.o_rsp0_valid = rsp_valid_q[0];
   assign bus.o_rsp1_valid = rsp_valid_q[1];
   assign bus.o_rsp0_rdata = rsp_valid_q[0] ? rdata_q : 32'h0;
   assign bus.o_rsp1_rdata = rsp_valid_q[1] ? rdata_q : 32'h0;
   assign bus.o_rsp0_err   = rsp_valid_q[0] & err_q;
   assign bus.o_rsp1_err   = rsp_valid_q[1] & err_q;

   assign o_memwrite   = memwrite_q;
   assign o_memread    = memread_q;
   assign o_address    = addr_q;
   assign o_write_data = wdata_q;

   a_strobe_excl: assert property (@(posedge i_clk) disable iff (i_rst)
      !(o_memread && o_memwrite));
   a_ready_excl: assert property (@(posedge i_clk) disable iff (i_rst)
      !(bus.o_req0_ready && bus.o_req1_ready));
   a_rsp_excl: assert property (@(posedge i_clk) disable iff (i_rst)
      !(bus.o_rsp0_valid && bus.o_rsp1_valid));

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Randomized bench for mem_data_arbiter against a transaction-level model of memory,
// address window, round-robin order and access latency.
module tb_mem_data_arbiter;
   localparam int unsigned ACC = 2;
   localparam logic [31:0] LO  = 32'h0000_3000;
   localparam logic [31:0] HI  = 32'h000E_FFFC;

   logic        clk = 1'b0;
   logic        rst;
   logic        memwrite, memread;
   logic [31:0] mem_addr, mem_wdata, rd_data;
   logic [31:0] mem [0:65535];

   int n_vec = 0;
   int n_err = 0;
   bit last_m;
   logic [31:0] ref_mem [logic [31:0]];

   mem_data_arbiter_if bus ();

   mem_data_arbiter #(.ACC_CYCLES(ACC), .ADDR_LO(LO), .ADDR_HI(HI)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .bus          (bus),
      .o_memwrite   (memwrite),
      .o_memread    (memread),
      .o_address    (mem_addr),
      .o_write_data (mem_wdata),
      .i_read_data  (rd_data)
   );

   always #5 clk = ~clk;

   // Memory environment: combinational read, write on the clock edge.
   assign rd_data = mem[mem_addr[17:2]];
   always @(posedge clk) if (memwrite) mem[mem_addr[17:2]] <= mem_wdata;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   function automatic bit is_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < LO) || (a > HI);
   endfunction

   function automatic logic [31:0] legal_addr();
      return LO + 32'(4 * $urandom_range(0, 63));
   endfunction

   function automatic logic [137:0] all_out();
      return {memwrite, memread, mem_addr, mem_wdata, bus.o_req0_ready, bus.o_req1_ready,
              bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_rsp0_rdata, bus.o_rsp1_rdata,
              bus.o_rsp0_err, bus.o_rsp1_err};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input bit v, input bit w, input logic [31:0] a,
                          input logic [31:0] d);
      if (p == 0) begin
         bus.i_req0_valid = v; bus.i_req0_write = w; bus.i_req0_addr = a; bus.i_req0_wdata = d;
      end else begin
         bus.i_req1_valid = v; bus.i_req1_write = w; bus.i_req1_addr = a; bus.i_req1_wdata = d;
      end
   endtask

   // Drives one request on port p (other port idle) and reports what the DUT did.
   task automatic run_txn(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output bit err, output int lat,
                          output int wr_cyc, output int rd_cyc, output logic [31:0] s_addr,
                          output logic [31:0] s_wdata, output bit both, output bit tmo);
      int k;
      bit got;
      rdata = 0; err = 0; lat = -1; wr_cyc = 0; rd_cyc = 0;
      s_addr = 0; s_wdata = 0; both = 0; tmo = 0; got = 0;
      set_req(p, 1'b1, w, a, d);
      if (p == 0) bus.i_rsp0_ready = 1'b1; else bus.i_rsp1_ready = 1'b1;
      #1;
      k = 0;
      while (!(p ? bus.o_req1_ready : bus.o_req0_ready) && k < 20) begin
         tick(); #1; k++;
      end
      if (k >= 20) begin
         tmo = 1;
         set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
         return;
      end
      tick();
      set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int c = 1; c <= 30; c++) begin
         if (p ? bus.o_rsp1_valid : bus.o_rsp0_valid) begin
            lat   = c;
            rdata = p ? bus.o_rsp1_rdata : bus.o_rsp0_rdata;
            err   = p ? bus.o_rsp1_err : bus.o_rsp0_err;
            got   = 1;
            tick();
            break;
         end
         if (memwrite) begin wr_cyc++; s_addr = mem_addr; s_wdata = mem_wdata; end
         if (memread) begin rd_cyc++; s_addr = mem_addr; s_wdata = mem_wdata; end
         if (memwrite && memread) both = 1;
         tick();
      end
      if (!got) tmo = 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_vec++;
      if (all_out() !== '0) begin
         n_err++; $display("FAIL reset_outputs: got %h want 0", all_out());
      end
      rst = 1'b0;
      tick();
      n_vec++;
      if (all_out() !== '0) begin
         n_err++; $display("FAIL post_reset_idle: got %h want 0", all_out());
      end
      last_m = 1;
   endtask

   task automatic test_store_load();
      logic [31:0] rd, sa, sw;
      bit er, bo, tmo;
      int lat, wc, rc;
      run_txn(0, 1'b1, 32'h3000, 32'hDEAD_BEEF, rd, er, lat, wc, rc, sa, sw, bo, tmo);
      ref_mem[32'h3000] = 32'hDEAD_BEEF;
      last_m = 0;
      n_vec++;
      if (tmo || wc != ACC || rc != 0 || sa !== 32'h3000 || sw !== 32'hDEAD_BEEF || bo) begin
         n_err++;
         $display("FAIL store_strobe: got tmo=%0d wr=%0d rd=%0d addr=%h wd=%h both=%0d want wr=%0d addr=3000 wd=deadbeef",
                  tmo, wc, rc, sa, sw, bo, ACC);
      end
      n_vec++;
      if (lat != ACC + 1 || er !== 1'b0 || rd !== 32'h0) begin
         n_err++;
         $display("FAIL store_rsp: got lat=%0d err=%0d rdata=%h want lat=%0d err=0 rdata=0",
                  lat, er, rd, ACC + 1);
      end
      run_txn(0, 1'b0, 32'h3000, 32'h1234_5678, rd, er, lat, wc, rc, sa, sw, bo, tmo);
      n_vec++;
      if (tmo || rc != ACC || wc != 0 || sa !== 32'h3000 || sw !== 32'h0) begin
         n_err++;
         $display("FAIL load_strobe: got tmo=%0d rd=%0d wr=%0d addr=%h wd=%h want rd=%0d addr=3000 wd=0",
                  tmo, rc, wc, sa, sw, ACC);
      end
      n_vec++;
      if (lat != ACC + 1 || er !== 1'b0 || rd !== ref_rd(32'h3000)) begin
         n_err++;
         $display("FAIL load_rsp: got lat=%0d err=%0d rdata=%h want lat=%0d err=0 rdata=%h",
                  lat, er, rd, ACC + 1, ref_rd(32'h3000));
      end
   endtask

   task automatic test_last_word();
      logic [31:0] rd, sa, sw;
      bit er, bo, tmo;
      int lat, wc, rc;
      run_txn(1, 1'b0, 32'h000E_FFFC, 32'h0, rd, er, lat, wc, rc, sa, sw, bo, tmo);
      last_m = 1;
      n_vec++;
      if (tmo || er !== 1'b0 || rc != ACC || sa !== 32'h000E_FFFC || rd !== ref_rd(32'hEFFFC)) begin
         n_err++;
         $display("FAIL last_word: got tmo=%0d err=%0d rd=%0d addr=%h rdata=%h want err=0 rd=%0d addr=000efffc",
                  tmo, er, rc, sa, rd, ACC);
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [5];
      logic [31:0] rd, sa, sw;
      bit er, bo, tmo;
      int lat, wc, rc;
      addrs[0] = 32'h3002; addrs[1] = 32'h2FFC; addrs[2] = 32'hF0000;
      addrs[3] = 32'hFFFF_FFFC; addrs[4] = 32'h3001;
      foreach (addrs[i]) begin
         run_txn(1, i[0], addrs[i], $urandom, rd, er, lat, wc, rc, sa, sw, bo, tmo);
         last_m = 1;
         n_vec++;
         if (tmo || er !== 1'b1 || rd !== 32'h0 || lat != 1 || wc != 0 || rc != 0) begin
            n_err++;
            $display("FAIL err_addr %h: got tmo=%0d err=%0d rdata=%h lat=%0d wr=%0d rd=%0d want err=1 rdata=0 lat=1 no strobes",
                     addrs[i], tmo, er, rd, lat, wc, rc);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d, rd, sa, sw, exp_rd;
      bit er, bo, tmo, w, bad;
      int lat, wc, rc, p, kind;
      for (int n = 0; n < 24; n++) begin
         p = $urandom_range(0, 1);
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         kind = $urandom_range(0, 6);
         case (kind)
            0: a = legal_addr() + 32'($urandom_range(1, 3));
            1: a = LO - 32'h4;
            2: a = HI + 32'h4;
            default: a = legal_addr();
         endcase
         bad = is_bad(a);
         exp_rd = (bad || w) ? 32'h0 : ref_rd(a);
         run_txn(p, w, a, d, rd, er, lat, wc, rc, sa, sw, bo, tmo);
         if (!bad && w) ref_mem[a] = d;
         last_m = p[0];
         n_vec++;
         if (tmo || er !== bad || rd !== exp_rd || lat != (bad ? 1 : ACC + 1)) begin
            n_err++;
            $display("FAIL rand_rsp #%0d p=%0d w=%0d a=%h: got tmo=%0d err=%0d rdata=%h lat=%0d want err=%0d rdata=%h lat=%0d",
                     n, p, w, a, tmo, er, rd, lat, bad, exp_rd, bad ? 1 : ACC + 1);
         end
         n_vec++;
         if (bo || wc != ((!bad && w) ? ACC : 0) || rc != ((!bad && !w) ? ACC : 0)
             || (!bad && (sa !== a || sw !== (w ? d : 32'h0)))) begin
            n_err++;
            $display("FAIL rand_strobe #%0d a=%h: got both=%0d wr=%0d rd=%0d addr=%h wd=%h",
                     n, a, bo, wc, rc, sa, sw);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a0, a1, exp;
      logic [31:0] q0 [$];
      logic [31:0] q1 [$];
      int grants, k, gcnt0, gcnt1, acc_p;
      bit p;
      a0 = legal_addr(); a1 = legal_addr();
      set_req(0, 1'b1, 1'b0, a0, 32'h0);
      set_req(1, 1'b1, 1'b0, a1, 32'h0);
      bus.i_rsp0_ready = 1'b1; bus.i_rsp1_ready = 1'b1;
      grants = 0; k = 0; gcnt0 = 0; gcnt1 = 0;
      while (grants < 8 && k < 100) begin
         #1;
         if (bus.o_rsp0_valid) begin
            exp = (q0.size() > 0) ? q0.pop_front() : 32'hX;
            n_vec++;
            if (bus.o_rsp0_rdata !== exp) begin
               n_err++; $display("FAIL b2b_rsp0: got %h want %h", bus.o_rsp0_rdata, exp);
            end
         end
         if (bus.o_rsp1_valid) begin
            exp = (q1.size() > 0) ? q1.pop_front() : 32'hX;
            n_vec++;
            if (bus.o_rsp1_rdata !== exp) begin
               n_err++; $display("FAIL b2b_rsp1: got %h want %h", bus.o_rsp1_rdata, exp);
            end
         end
         acc_p = -1;
         if (bus.o_req0_ready || bus.o_req1_ready) begin
            p = bus.o_req1_ready;
            n_vec++;
            if ((bus.o_req0_ready && bus.o_req1_ready) || p == last_m) begin
               n_err++;
               $display("FAIL b2b_grant #%0d: got ready0=%0d ready1=%0d want only port %0d",
                        grants, bus.o_req0_ready, bus.o_req1_ready, !last_m);
            end
            last_m = p;
            if (p) begin q1.push_back(ref_rd(a1)); gcnt1++; end
            else begin q0.push_back(ref_rd(a0)); gcnt0++; end
            grants++;
            acc_p = p;
         end
         if (grants < 8) begin
            tick();
            if (acc_p == 0) begin a0 = legal_addr(); set_req(0, 1'b1, 1'b0, a0, 32'h0); end
            if (acc_p == 1) begin a1 = legal_addr(); set_req(1, 1'b1, 1'b0, a1, 32'h0); end
         end
         k++;
      end
      tick();
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      k = 0;
      while ((q0.size() > 0 || q1.size() > 0) && k < 30) begin
         if (bus.o_rsp0_valid && q0.size() > 0) begin
            exp = q0.pop_front();
            n_vec++;
            if (bus.o_rsp0_rdata !== exp) begin
               n_err++; $display("FAIL b2b_drain0: got %h want %h", bus.o_rsp0_rdata, exp);
            end
         end
         if (bus.o_rsp1_valid && q1.size() > 0) begin
            exp = q1.pop_front();
            n_vec++;
            if (bus.o_rsp1_rdata !== exp) begin
               n_err++; $display("FAIL b2b_drain1: got %h want %h", bus.o_rsp1_rdata, exp);
            end
         end
         tick();
         k++;
      end
      n_vec++;
      if (q0.size() != 0 || q1.size() != 0 || gcnt0 != 4 || gcnt1 != 4) begin
         n_err++;
         $display("FAIL b2b_fairness: got grants0=%0d grants1=%0d pending=%0d/%0d want 4/4, 0/0",
                  gcnt0, gcnt1, q0.size(), q1.size());
      end
      tick();
   endtask

   task automatic test_stall();
      logic [31:0] a, b, exp;
      int k;
      bit seen_r1, got;
      a = legal_addr(); b = legal_addr();
      exp = ref_rd(a);
      bus.i_rsp0_ready = 1'b0; bus.i_rsp1_ready = 1'b1;
      set_req(0, 1'b1, 1'b0, a, 32'h0);
      #1;
      k = 0;
      while (!bus.o_req0_ready && k < 20) begin tick(); #1; k++; end
      tick();
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(1, 1'b1, 1'b0, b, 32'h0);
      seen_r1 = 0; got = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (bus.o_req1_ready) seen_r1 = 1;
         if (bus.o_rsp0_valid) begin got = 1; break; end
         tick();
      end
      n_vec++;
      if (!got || seen_r1) begin
         n_err++; $display("FAIL stall_setup: got rsp0=%0d ready1_seen=%0d want 1/0", got, seen_r1);
      end
      for (int c = 0; c < 5; c++) begin
         n_vec++;
         if (bus.o_rsp0_valid !== 1'b1 || bus.o_rsp0_rdata !== exp || bus.o_req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold cyc%0d: got valid=%0d rdata=%h ready1=%0d want 1 %h 0",
                     c, bus.o_rsp0_valid, bus.o_rsp0_rdata, bus.o_req1_ready, exp);
         end
         tick(); #1;
      end
      bus.i_rsp0_ready = 1'b1;
      tick(); #1;
      n_vec++;
      if (bus.o_rsp0_valid !== 1'b0 || bus.o_req1_ready !== 1'b1) begin
         n_err++;
         $display("FAIL stall_release: got rsp0=%0d ready1=%0d want 0 1", bus.o_rsp0_valid,
                  bus.o_req1_ready);
      end
      last_m = 1;
      tick();
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      got = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.o_rsp1_valid) begin
            got = 1;
            n_vec++;
            if (bus.o_rsp1_rdata !== ref_rd(b)) begin
               n_err++; $display("FAIL stall_port1: got %h want %h", bus.o_rsp1_rdata, ref_rd(b));
            end
            break;
         end
         tick();
      end
      n_vec++;
      if (!got) begin n_err++; $display("FAIL stall_port1_timeout: got no rsp1 want rsp1"); end
      tick();
   endtask

   task automatic test_reset_mid_access();
      int k;
      bit bad, got;
      bus.i_rsp0_ready = 1'b1; bus.i_rsp1_ready = 1'b1;
      set_req(0, 1'b1, 1'b1, 32'h4000, $urandom);
      #1;
      k = 0;
      while (!bus.o_req0_ready && k < 20) begin tick(); #1; k++; end
      tick();
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      n_vec++;
      if (memwrite !== 1'b1 || mem_addr !== 32'h4000) begin
         n_err++; $display("FAIL rst_mid_pre: got memwrite=%0d addr=%h want 1 00004000", memwrite,
                           mem_addr);
      end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if (all_out() !== '0) begin
         n_err++; $display("FAIL rst_mid_outputs: got %h want 0", all_out());
      end
      last_m = 1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         if (bus.o_rsp0_valid || bus.o_rsp1_valid || memwrite || memread) bad = 1;
         tick();
      end
      n_vec++;
      if (bad) begin n_err++; $display("FAIL rst_mid_no_rsp: got activity want none"); end
      set_req(0, 1'b1, 1'b0, 32'h3000, 32'h0);
      set_req(1, 1'b1, 1'b0, 32'h3004, 32'h0);
      #1;
      n_vec++;
      if (bus.o_req0_ready !== 1'b1 || bus.o_req1_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_first_grant: got ready0=%0d ready1=%0d want 1 0", bus.o_req0_ready,
                  bus.o_req1_ready);
      end
      tick();
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      got = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.o_rsp0_valid) begin
            got = 1;
            n_vec++;
            if (bus.o_rsp0_rdata !== ref_rd(32'h3000)) begin
               n_err++; $display("FAIL rst_mid_load: got %h want %h", bus.o_rsp0_rdata,
                                 ref_rd(32'h3000));
            end
            break;
         end
         tick();
      end
      n_vec++;
      if (!got) begin n_err++; $display("FAIL rst_mid_load_timeout: got no rsp0 want rsp0"); end
      tick();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      rst = 1'b1;
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      bus.i_rsp0_ready = 1'b0;
      bus.i_rsp1_ready = 1'b0;
      test_reset();
      test_store_load();
      test_last_word();
      test_errors();
      test_random();
      test_back_to_back();
      test_stall();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_data_arbiter.md
Name: mem_data_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the single-ported data memory.
- Port 0 is the CPU MEM stage; port 1 is the program/data loader.
- Each side uses a valid/ready request and a valid/ready response.
- Only one access is in flight at a time. Alignment and address-window errors are answered without touching memory.

Parameters:
ACC_CYCLES, 2, cycles memory strobe held per access (>=1); read data sampled on last cycle
ADDR_LO, 32'h0000_3000, lowest legal byte address (word 0xC00)
ADDR_HI, 32'h000E_FFFC, highest legal byte address (word 0x3BFFF)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_reqN_valid  in  1  (N=0,1) request valid
o_reqN_ready  out  1  request accepted this cycle
i_reqN_write  in  1  1=store, 0=load
i_reqN_addr  in  32  byte address
i_reqN_wdata  in  32  store data
o_rspN_valid  out  1  response valid
i_rspN_ready  in  1  response consumed
o_rspN_rdata  out  32  load data (0 for stores/errors)
o_rspN_err  out  1  misaligned or out-of-window
o_memwrite  out  1  memory write strobe
o_memread  out  1  memory read strobe
o_address  out  32  memory byte address
o_write_data  out  32  memory write data
i_read_data  in  32  memory read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset: state IDLE; all o_* are 0; RR pointer last=1, so port 0 wins first contention. Reset mid-access or mid-response aborts it: strobes drop next edge, no response is issued, and the latched request is discarded.
- IDLE:
  - o_reqN_ready = (state==IDLE) & grantN. It is combinational and at most one is high.
  - Grant rule: only one valid -> that port. Both valid -> the port != last. Update last on accept.
  - On accept: latch port id, write, addr, wdata.
  - Error check: addr[1:0]!=0, or addr<ADDR_LO, or addr>ADDR_HI -> go to RESP with err=1. Otherwise go to ACCESS with counter=0.
- ACCESS:
  - o_address = latched addr; o_write_data = latched wdata (0 for loads). o_memwrite = write; o_memread = ~write.
  - Strobes are held exactly ACC_CYCLES cycles.
  - On the last cycle, a load captures i_read_data. Then go to RESP with err=0.
  - Requesters' valid/data may change freely during ACCESS.
- RESP:
  - o_rspN_valid=1 for the latched port only. rdata/err are stable until the handshake.
  - Strobes are 0 and o_address/o_write_data return to 0.
  - When i_rspN_ready=1: go to IDLE next cycle.
  - No new request is accepted in the RESP cycle. Back-to-back throughput is 1 access per ACC_CYCLES+2 cycles.
- Latency: accept at cycle t; strobes t+1..t+ACC_CYCLES; rsp_valid from t+ACC_CYCLES+1. Error path: rsp_valid at t+1.
- Memory strobes are never asserted outside ACCESS; o_memread and o_memwrite are never high together.
- Store response: rdata=0, err=0.
- A response stalled by rsp_ready=0 holds indefinitely and blocks both ports.
- Request with valid dropped before ready: no side effect.
- Address window compare is unsigned over full 32 bits; no wrap.

Test Plan:
- Port0 store addr 0x3000 data 0xDEADBEEF, then load 0x3000 -> memwrite high 2 cycles with address 0x3000; load rsp rdata=0xDEADBEEF, err=0, rsp_valid 3 cycles after accept.
- Both ports valid every cycle after reset, all loads -> grants alternate 0,1,0,1; port 1 never starved; ready never high on both.
- Port1 load addr 0x3002, then 0x2FFC, then 0xF0000 -> each rsp err=1, rdata=0, rsp_valid 1 cycle after accept, memread/memwrite stay 0.
- Port0 load with i_rsp0_ready held 0 for 5 cycles while port1 requests -> rsp0_valid and rdata stable 5 cycles; o_req1_ready stays 0 until after the rsp0 handshake.
- Assert i_rst during the 2nd ACCESS cycle of a store to 0x4000 -> next cycle all outputs 0, state IDLE, no response; port 0 wins the first post-reset contention.
- Load of the last legal word 0xEFFFC -> err=0, memread asserted with o_address=0xEFFFC.
